// File: rtl/impulse_capture.sv
// impulse_capture
//   Once armed, skips one audio step and then records CAPTURE_LEN microphone
//   samples into an internal RAM. While recording it tracks the first sample
//   whose magnitude reaches THRESHOLD (onset) and the first sample of largest
//   magnitude (peak). The captured window is read back via a registered port.
//
// Ports
//   clk_in           system clock
//   rst_n_in         asynchronous active-low reset
//   step_in          one-cycle audio-rate strobe
//   arm_in           start a capture (honoured only when idle)
//   mic_in           signed mic sample, valid with step_in
//   busy_out         high from arm acceptance until the window is complete
//   done_out         one-cycle pulse after the final write
//   onset_valid_out  an onset was seen in the last capture
//   onset_idx_out    index of the first sample with |x| >= THRESHOLD
//   peak_amp_out     largest saturated magnitude seen
//   peak_idx_out     index of the first sample with that magnitude
//   rd_en_in         read request
//   rd_addr_in       read index
//   rd_data_out      captured sample, one cycle after rd_en_in
//   rd_valid_out     qualifies rd_data_out
module impulse_capture #(
    parameter int          CAPTURE_LEN = 256,
    parameter int          ADDR_W      = $clog2(CAPTURE_LEN),
    parameter logic [15:0] THRESHOLD   = 16'd4096
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     step_in,
    input  logic                     arm_in,
    input  logic signed [15:0]       mic_in,
    output logic                     busy_out,
    output logic                     done_out,
    output logic                     onset_valid_out,
    output logic [ADDR_W-1:0]        onset_idx_out,
    output logic [15:0]              peak_amp_out,
    output logic [ADDR_W-1:0]        peak_idx_out,
    input  logic                     rd_en_in,
    input  logic [ADDR_W-1:0]        rd_addr_in,
    output logic signed [15:0]       rd_data_out,
    output logic                     rd_valid_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(CAPTURE_LEN - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_arm_accept;
    logic                   w_rec;
    logic                   w_last;
    logic [15:0]            w_mag;

    logic [ADDR_W-1:0]      r_idx;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_onset_valid;
    logic [ADDR_W-1:0]      r_onset_idx;
    logic [15:0]            r_peak_amp;
    logic [ADDR_W-1:0]      r_peak_idx;
    logic signed [15:0]     r_rd_data;
    logic                   r_rd_valid;

    logic signed [15:0]     r_mem [CAPTURE_LEN];

    // Magnitude with -32768 saturated to 32767 so it fits 16 bits unsigned.
    function automatic logic [15:0] sat_abs(input logic signed [15:0] x);
        logic [15:0] neg;
        neg = ~x + 16'd1;
        if (x == 16'sh8000) begin
            return 16'h7FFF;
        end else if (x[15]) begin
            return neg;
        end else begin
            return x;
        end
    endfunction

    assign w_mag = sat_abs(mic_in);

    always_comb begin
        w_state_nxt  = r_state;
        w_arm_accept = 1'b0;
        w_rec        = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (arm_in) begin
                    w_arm_accept = 1'b1;
                    w_state_nxt  = ARMED;
                end
            end
            // The first step after arming is discarded to align the window
            // one sample after the generator fires.
            ARMED: begin
                if (step_in) begin
                    w_state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (step_in) begin
                    w_rec = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_last      = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_idx         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_onset_valid <= 1'b0;
            r_onset_idx   <= '0;
            r_peak_amp    <= '0;
            r_peak_idx    <= '0;
        end else begin
            r_done <= w_last;
            if (w_arm_accept) begin
                r_busy        <= 1'b1;
                r_idx         <= '0;
                r_onset_valid <= 1'b0;
                r_onset_idx   <= '0;
                r_peak_amp    <= '0;
                r_peak_idx    <= '0;
            end else if (w_rec) begin
                if (!r_onset_valid && (w_mag >= THRESHOLD)) begin
                    r_onset_valid <= 1'b1;
                    r_onset_idx   <= r_idx;
                end
                // Strict compare keeps the earliest index on ties.
                if (w_mag > r_peak_amp) begin
                    r_peak_amp <= w_mag;
                    r_peak_idx <= r_idx;
                end
                r_idx <= r_idx + 1'b1;
                if (w_last) begin
                    r_busy <= 1'b0;
                end
            end
        end
    end

    // Sample RAM: not reset, contents persist across captures.
    always_ff @(posedge clk_in) begin
        if (w_rec) begin
            r_mem[r_idx] <= mic_in;
        end
    end

    // Registered read; a same-cycle write to the same address is not seen.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en_in;
            if (rd_en_in) begin
                r_rd_data <= r_mem[rd_addr_in];
            end
        end
    end

    assign busy_out        = r_busy;
    assign done_out        = r_done;
    assign onset_valid_out = r_onset_valid;
    assign onset_idx_out   = r_onset_idx;
    assign peak_amp_out    = r_peak_amp;
    assign peak_idx_out    = r_peak_idx;
    assign rd_data_out     = r_rd_data;
    assign rd_valid_out    = r_rd_valid;

endmodule

// File: tb/tb_impulse_capture.sv
module tb_impulse_capture;

    localparam int LEN = 256;
    localparam int AW  = 8;

    logic                 clk_in = 1'b0;
    logic                 rst_n_in;
    logic                 step_in;
    logic                 arm_in;
    logic signed [15:0]   mic_in;
    logic                 busy_out;
    logic                 done_out;
    logic                 onset_valid_out;
    logic [AW-1:0]        onset_idx_out;
    logic [15:0]          peak_amp_out;
    logic [AW-1:0]        peak_idx_out;
    logic                 rd_en_in;
    logic [AW-1:0]        rd_addr_in;
    logic signed [15:0]   rd_data_out;
    logic                 rd_valid_out;

    always #5 clk_in = ~clk_in;

    impulse_capture #(
        .CAPTURE_LEN (LEN),
        .ADDR_W      (AW),
        .THRESHOLD   (16'd4096)
    ) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .step_in         (step_in),
        .arm_in          (arm_in),
        .mic_in          (mic_in),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .onset_valid_out (onset_valid_out),
        .onset_idx_out   (onset_idx_out),
        .peak_amp_out    (peak_amp_out),
        .peak_idx_out    (peak_idx_out),
        .rd_en_in        (rd_en_in),
        .rd_addr_in      (rd_addr_in),
        .rd_data_out     (rd_data_out),
        .rd_valid_out    (rd_valid_out)
    );

    int errors = 0;
    int checks = 0;
    int done_total = 0;

    logic signed [15:0] samp  [LEN];
    logic signed [15:0] ram_m [LEN];
    bit                 ram_k [LEN];

    int e_onv, e_oni, e_pa, e_pi;

    always @(negedge clk_in) begin
        if (done_out === 1'b1) done_total++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic int mag(input int v);
        int a;
        a = (v < 0) ? -v : v;
        return (a > 32767) ? 32767 : a;
    endfunction

    // Reference: onset = first index reaching threshold; peak = max magnitude,
    // index = first position holding that maximum.
    function automatic void model();
        int mx;
        e_onv = 0;
        e_oni = 0;
        for (int i = 0; i < LEN; i++) begin
            if (mag(int'(samp[i])) >= 4096) begin
                e_onv = 1;
                e_oni = i;
                break;
            end
        end
        mx = 0;
        for (int i = 0; i < LEN; i++) begin
            if (mag(int'(samp[i])) > mx) mx = mag(int'(samp[i]));
        end
        e_pa = mx;
        e_pi = 0;
        for (int i = LEN - 1; i >= 0; i--) begin
            if (mag(int'(samp[i])) == mx) e_pi = i;
        end
    endfunction

    task automatic idle_gap(input bit gaps);
        int n;
        n = gaps ? int'($urandom_range(0, 2)) : 0;
        repeat (n) begin
            step_in = 1'b0;
            arm_in  = 1'($urandom_range(0, 1));
            mic_in  = 16'($urandom);
            tick();
        end
        arm_in = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"},  32'(busy_out), 32'd0);
        chk({tag, "_done"},  32'(done_out), 32'd0);
        chk({tag, "_onv"},   32'(onset_valid_out), 32'd0);
        chk({tag, "_oni"},   32'(onset_idx_out), 32'd0);
        chk({tag, "_pa"},    32'(peak_amp_out), 32'd0);
        chk({tag, "_pi"},    32'(peak_idx_out), 32'd0);
        chk({tag, "_rdd"},   32'(rd_data_out), 32'd0);
        chk({tag, "_rdv"},   32'(rd_valid_out), 32'd0);
    endtask

    task automatic run_capture(input string tag, input int arm_at,
                               input bit arm_with_step, input bit gaps);
        int d0;
        d0 = done_total;
        model();
        arm_in  = 1'b1;
        step_in = arm_with_step;
        mic_in  = 16'($urandom);
        tick();
        arm_in  = 1'b0;
        step_in = 1'b0;
        chk({tag, "_busy_arm"}, 32'(busy_out), 32'd1);
        chk({tag, "_onv_clr"}, 32'(onset_valid_out), 32'd0);
        chk({tag, "_pa_clr"}, 32'(peak_amp_out), 32'd0);
        idle_gap(gaps);
        step_in = 1'b1;
        mic_in  = 16'sh7FFF;
        tick();
        step_in = 1'b0;
        for (int i = 0; i < LEN; i++) begin
            idle_gap(gaps);
            step_in = 1'b1;
            mic_in  = samp[i];
            arm_in  = (i == arm_at);
            if ((i % 64) == 5) begin
                rd_en_in   = 1'b1;
                rd_addr_in = AW'(i);
            end
            tick();
            step_in = 1'b0;
            arm_in  = 1'b0;
            if (rd_en_in) begin
                if (ram_k[i]) chk($sformatf("%s_rd_old_%0d", tag, i), 32'(rd_data_out), 32'(ram_m[i]));
                rd_en_in = 1'b0;
            end
            ram_m[i] = samp[i];
            ram_k[i] = 1'b1;
            if (i == LEN - 2) begin
                chk({tag, "_busy_mid"}, 32'(busy_out), 32'd1);
                chk({tag, "_done_early"}, 32'(done_out), 32'd0);
            end
        end
        chk({tag, "_done"}, 32'(done_out), 32'd1);
        chk({tag, "_busy_end"}, 32'(busy_out), 32'd0);
        chk({tag, "_onv"}, 32'(onset_valid_out), 32'(e_onv));
        if (e_onv != 0) chk({tag, "_oni"}, 32'(onset_idx_out), 32'(e_oni));
        chk({tag, "_pa"}, 32'(peak_amp_out), 32'(e_pa));
        chk({tag, "_pi"}, 32'(peak_idx_out), 32'(e_pi));
        tick();
        chk({tag, "_done_drop"}, 32'(done_out), 32'd0);
        tick();
        chk({tag, "_done_cnt"}, 32'(done_total - d0), 32'd1);
        chk({tag, "_pa_hold"}, 32'(peak_amp_out), 32'(e_pa));
    endtask

    task automatic readback(input string tag);
        rd_en_in = 1'b1;
        for (int a = 0; a < LEN; a++) begin
            rd_addr_in = AW'(a);
            tick();
            chk({tag, "_rdv"}, 32'(rd_valid_out), 32'd1);
            if (ram_k[a]) chk($sformatf("%s_rd_%0d", tag, a), 32'(rd_data_out), 32'(ram_m[a]));
        end
        rd_en_in   = 1'b0;
        rd_addr_in = '0;
        tick();
        chk({tag, "_rdv_low"}, 32'(rd_valid_out), 32'd0);
        chk({tag, "_rd_hold"}, 32'(rd_data_out), 32'(ram_m[LEN-1]));
    endtask

    task automatic fill_random(input int lo, input int hi);
        for (int i = 0; i < LEN; i++) samp[i] = 16'($urandom_range(0, hi - lo) + lo);
    endtask

    initial begin
        rst_n_in   = 1'b0;
        step_in    = 1'b0;
        arm_in     = 1'b0;
        mic_in     = '0;
        rd_en_in   = 1'b0;
        rd_addr_in = '0;
        for (int i = 0; i < LEN; i++) begin
            ram_k[i] = 1'b0;
            ram_m[i] = '0;
        end
        repeat (3) tick();
        check_outputs_zero("reset");
        rst_n_in = 1'b1;
        tick();

        // Ramp 0..255
        for (int i = 0; i < LEN; i++) samp[i] = 16'(i);
        run_capture("ramp", -1, 1'b0, 1'b1);
        readback("ramp");

        // Equal-magnitude opposite-sign pulses: first one wins
        for (int i = 0; i < LEN; i++) samp[i] = '0;
        samp[37] = -16'sd9000;
        samp[80] = 16'sd9000;
        run_capture("pulses", -1, 1'b0, 1'b0);

        // Most-negative value saturates
        fill_random(-4095, 4095);
        samp[10] = 16'sh8000;
        run_capture("satneg", -1, 1'b0, 1'b1);
        readback("satneg");

        // Re-arm mid-capture ignored, then arm with a coincident step
        fill_random(-32768, 32767);
        run_capture("rearm", 50, 1'b0, 1'b1);
        fill_random(-32768, 32767);
        run_capture("armstep", -1, 1'b1, 1'b0);
        readback("armstep");

        // Reset during capture
        fill_random(-32768, 32767);
        arm_in = 1'b1;
        tick();
        arm_in  = 1'b0;
        step_in = 1'b1;
        mic_in  = '0;
        tick();
        for (int i = 0; i < 100; i++) begin
            mic_in = samp[i];
            tick();
        end
        step_in = 1'b0;
        chk("abort_busy_pre", 32'(busy_out), 32'd1);
        #3;
        rst_n_in = 1'b0;
        #1;
        check_outputs_zero("abort");
        tick();
        rst_n_in = 1'b1;
        for (int i = 0; i < LEN; i++) ram_k[i] = 1'b0;
        tick();
        fill_random(-32768, 32767);
        run_capture("after_abort", -1, 1'b0, 1'b1);
        readback("after_abort");

        // Threshold boundary exactly at 4096 on sample 0
        for (int i = 0; i < LEN; i++) samp[i] = '0;
        samp[0] = 16'sd4096;
        run_capture("thr_eq", -1, 1'b0, 1'b0);

        // Just below threshold everywhere
        for (int i = 0; i < LEN; i++) samp[i] = 16'sd4095;
        run_capture("thr_below", -1, 1'b0, 1'b0);

        // Random windows, some sparse onsets
        for (int r = 0; r < 3; r++) begin
            fill_random(-3000, 3000);
            samp[$urandom_range(0, LEN-1)] = 16'($urandom);
            samp[$urandom_range(0, LEN-1)] = 16'($urandom);
            run_capture($sformatf("rand%0d", r), -1, 1'(r & 1), 1'b1);
        end
        readback("rand_last");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/impulse_capture.md
# impulse_capture

Receive-side counterpart to the impulse generator: once armed, it records a fixed window of microphone samples at the audio step rate into internal RAM. While recording, it locates the first sample whose magnitude crosses a threshold (acoustic onset) and the largest-magnitude sample (peak). It sits between the mic sample path and the latency/echo-estimation logic, and it exposes the captured window through a one-cycle-latency read port.

## Interface
- CAPTURE_LEN, 256: samples recorded per capture; power of two, 16..4096.
- ADDR_W, $clog2(CAPTURE_LEN): sample index width.
- THRESHOLD, 16'd4096: unsigned magnitude that defines onset.
- clk_in  in  1  system clock; the only clock.
- rst_n_in  in  1  reset, asynchronous, active-low.
- step_in  in  1  audio-rate strobe, high one cycle per sample period.
- arm_in  in  1  start a capture; sampled every cycle.
- mic_in  in  16  signed mic sample, valid on cycles with step_in high.
- busy_out  out  1  high from arm acceptance until capture completes.
- done_out  out  1  one-cycle pulse when the window is complete.
- onset_valid_out  out  1  an onset was found in the last capture.
- onset_idx_out  out  ADDR_W  index of first sample with |x| >= THRESHOLD.
- peak_amp_out  out  16  unsigned magnitude of the largest sample.
- peak_idx_out  out  ADDR_W  index of that sample (first occurrence).
- rd_en_in  in  1  read request.
- rd_addr_in  in  ADDR_W  read index.
- rd_data_out  out  16  signed captured sample.
- rd_valid_out  out  1  rd_data_out valid; high exactly one cycle after rd_en_in.

## Operation
- States: IDLE, ARMED, CAPTURE.
- IDLE:
  - arm_in=1 clears onset_valid_out, onset_idx_out, peak_amp_out, peak_idx_out and the write index.
  - The same edge asserts busy_out and moves to ARMED.
  - A step_in in the arm cycle is ignored.
- ARMED: the next step_in moves to CAPTURE. That sample is not recorded, which aligns capture to one sample after the generator fires.
- CAPTURE, on each step_in:
  - Write mic_in to RAM[idx] and compute magnitude m = |mic_in|. -32768 saturates to 32767; m is 16-bit unsigned.
  - If onset_valid_out=0 and m >= THRESHOLD: set onset_valid_out=1 and onset_idx_out=idx.
  - If m > peak_amp_out (strictly greater): peak_amp_out=m and peak_idx_out=idx. Ties keep the earlier index. An all-zero window leaves peak_idx_out=0.
  - idx increments. On the write at idx=CAPTURE_LEN-1, go to IDLE: busy_out=0 and done_out=1 on the following cycle.
- arm_in while in ARMED or CAPTURE is ignored; there is no restart.
- Results hold until the next accepted arm. RAM contents persist across captures; reset does not clear RAM.
- Read port is independent of state:
  - rd_en_in at cycle t gives rd_data_out=RAM[rd_addr_in] and rd_valid_out=1 at t+1.
  - rd_data_out holds its value when rd_en_in=0.
  - A read of the address being written in the same cycle returns the old contents.
- Reset mid-capture aborts: return to IDLE. Partial RAM contents are undefined for verification.

## Timing
- Reset values: busy_out=0, done_out=0, onset_valid_out=0, onset_idx_out=0, peak_amp_out=0, peak_idx_out=0, rd_data_out=0, rd_valid_out=0; state IDLE.
- All outputs are registered; there are no combinational input-to-output paths.
- Arm edge to busy_out high: 1 cycle.
- Result registers update on the same edge as the RAM write for that sample.
- done_out is high for exactly one cycle, on the cycle after the final write edge, coincident with busy_out falling.
- Capture duration: 1 + CAPTURE_LEN step_in strobes after arm (one skipped, CAPTURE_LEN recorded).
- step_in back-to-back on consecutive cycles must be supported at full throughput.

## Test plan
- Arm, then feed CAPTURE_LEN=256 samples x[i]=i (after the skipped step) -> done_out pulses once, onset_valid_out=0, peak_amp_out=255, peak_idx_out=255; reads of addr 0..255 return 0..255, each with rd_valid_out one cycle after rd_en_in.
- Window of zeros except x[37]=-9000 and x[80]=9000 -> onset_idx_out=37, peak_amp_out=9000, peak_idx_out=37 (tie keeps first).
- x[10]=-32768 -> peak_amp_out=32767, onset_idx_out=10.
- arm_in pulsed again at sample 50 of a capture -> ignored; done_out after sample 255; then arm from IDLE with step_in high in the same cycle -> that step is not counted.
- Deassert rst_n_in at sample 100 -> all outputs 0 asynchronously; a new arm then gives a complete, correct capture.
- x[0]=4096 exactly -> onset_valid_out=1, onset_idx_out=0; x all 4095 -> onset_valid_out=0, peak_idx_out=0.
